led_pattern_ctrl: RTL
=====================

Name: led_pattern_ctrl

Overview:
- Consumes the single-cycle `tick_enable` strobe from the enable generator and steps an LED pattern by exactly one step per strobe.
- Four patterns are selectable: blink-all, chase, bounce, binary count.
- A one-cycle `mode_next` pulse cycles the selected pattern. It comes from the debounced button stage upstream.
- Drives the board LED pins directly through registered outputs.

Parameters:
- `NUM_LEDS`, default 8: number of LED outputs; legal range is NUM_LEDS ≥ 2.

Ports:
- `sys_clk`  input  1: system clock; all logic on the rising edge.
- `sys_rst_n`  input  1: asynchronous active-low reset.
- `tick_enable`  input  1: one-cycle step strobe from the enable generator.
- `run`  input  1: 1 = pattern advances on ticks; 0 = pattern frozen.
- `mode_next`  input  1: one-cycle pulse; advance to the next mode.
- `led_out`  output  NUM_LEDS: LED drive, registered.
- `mode_o`  output  2: current mode, registered.

Behaviour:
- Reset (async assert, sync release):
  - `mode_o` = BLINK (0), `led_out` = 0, bounce direction = UP.
  - Reset mid-pattern returns to this state immediately.
- Mode encoding and sequence:
  - 0 BLINK, 1 CHASE, 2 BOUNCE, 3 BINARY.
  - `mode_next` advances 0→1→2→3→0; wraps after BINARY.
- Mode change:
  - On the edge sampling `mode_next` = 1, `mode_o` advances.
  - On the same edge, `led_out` loads the new mode's start value.
  - Bounce direction resets to UP.
  - Takes effect regardless of `run`.
- Start values:
  - BLINK: all zeros.
  - CHASE: one-hot at bit 0.
  - BOUNCE: one-hot at bit 0.
  - BINARY: zero.
- Step condition: `tick_enable` = 1 AND `run` = 1 AND `mode_next` = 0, sampled on a clock edge. The updated `led_out` is visible after that edge (1-cycle latency from the tick).
- Steps per mode:
  - BLINK: `led_out` ← ~`led_out` (all bits toggle together).
  - CHASE: rotate left by 1; MSB wraps to bit 0.
  - BOUNCE:
    - Direction UP: shift left. If the shifted result has the MSB set, direction ← DOWN on the same edge.
    - Direction DOWN: shift right. If the result has bit 0 set, direction ← UP.
    - The endpoint is shown for exactly one tick; no repeat.
    - NUM_LEDS=4 sequence: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - BINARY: `led_out` ← `led_out` + 1, modulo 2^NUM_LEDS; all-ones wraps to 0.
- Simultaneous events:
  - `mode_next` and `tick_enable` on the same cycle: the mode change wins and the tick is dropped. The new mode shows its start value.
  - `run` = 0 with `tick_enable` = 1: no change; the tick is not queued.
- Invariants:
  - In CHASE/BOUNCE, `led_out` is always one-hot.
  - No state change when `tick_enable` = 0, except via `mode_next`.
- Structure: bounce direction is a 2-state FSM (UP, DOWN), meaningful only in BOUNCE and held otherwise. The mode register is a 4-state FSM.

Decomposition:
- Shared package `led_pkg`:
  - Mode encodings `MODE_BLINK`/`MODE_CHASE`/`MODE_BOUNCE`/`MODE_BINARY` (2-bit).
  - Direction encodings `DIR_UP`/`DIR_DOWN`.
  - `MODE_W` = 2.
- No sub-module is natural; the block is flat.
- Top level instantiates the enable generator and this block side by side, wiring its tick output to `tick_enable`.

Test Plan (NUM_LEDS=4, tick every 4 clocks unless stated):
- Reset then 3 ticks, `run` = 1 → `mode_o` = 0; `led_out` 0000 → 1111 → 0000 → 1111, each one cycle after its tick.
- Enter CHASE via 1 `mode_next` pulse → `led_out` = 0001 immediately; 5 ticks give 0010, 0100, 1000, 0001, 0010.
- BOUNCE, 8 ticks from start → 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100; `led_out` one-hot every cycle.
- BINARY, 17 ticks → counts 0001…1111, then 0000, then 0001; hold `run` = 0 across 3 ticks → value unchanged.
- `mode_next` coincident with `tick_enable` while in BINARY at 0101 → `mode_o` = 0, `led_out` = 0000 (tick dropped); in BLINK, `mode_next` then 4 more pulses → `mode_o` wraps back to 1.
- Assert `sys_rst_n` low mid-clock during BOUNCE at 1000, direction DOWN → `led_out` = 0000 and `mode_o` = 0 immediately without a clock; after release, BLINK resumes from 0000.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern controller: pattern modes and the
// bounce direction used while the BOUNCE pattern is active.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BINARY = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_pattern_ctrl.sv
// LED pattern stepper: one pattern step per qualified tick, with a button
// pulse cycling through blink, chase, bounce and binary-count patterns.
module led_pattern_ctrl #(
  parameter int NUM_LEDS = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                tick_enable,
  input  logic                run,
  input  logic                mode_next,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [1:0]          mode_o
);

  import led_pkg::*;

  localparam logic [NUM_LEDS-1:0] LED_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  mode_t               r_mode;
  dir_t                r_dir;
  logic [NUM_LEDS-1:0] r_led;

  mode_t               w_nextMode;
  logic [NUM_LEDS-1:0] w_start;
  logic [NUM_LEDS-1:0] w_step;
  dir_t                w_stepDir;

  always_comb begin
    w_nextMode = mode_t'(r_mode + 2'd1);
    w_start    = '0;
    if (w_nextMode == MODE_CHASE || w_nextMode == MODE_BOUNCE) begin
      w_start = LED_ONE;
    end
  end

  // The bounce turns around on the same edge that lands on an endpoint,
  // so each endpoint is shown for exactly one tick.
  always_comb begin
    w_step    = r_led;
    w_stepDir = r_dir;
    unique case (r_mode)
      MODE_BLINK:  w_step = ~r_led;
      MODE_CHASE:  w_step = {r_led[NUM_LEDS-2:0], r_led[NUM_LEDS-1]};
      MODE_BOUNCE: begin
        if (r_dir == DIR_UP) begin
          w_step = r_led << 1;
          if (w_step[NUM_LEDS-1]) w_stepDir = DIR_DOWN;
        end else begin
          w_step = r_led >> 1;
          if (w_step[0]) w_stepDir = DIR_UP;
        end
      end
      MODE_BINARY: w_step = r_led + LED_ONE;
      default:     w_step = r_led;
    endcase
  end

  // A mode change outranks a coincident tick, which is simply dropped.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode <= MODE_BLINK;
      r_led  <= '0;
      r_dir  <= DIR_UP;
    end else if (mode_next) begin
      r_mode <= w_nextMode;
      r_led  <= w_start;
      r_dir  <= DIR_UP;
    end else if (tick_enable && run) begin
      r_led  <= w_step;
      r_dir  <= w_stepDir;
    end
  end

  assign led_out = r_led;
  assign mode_o  = r_mode;

endmodule
